// File: rtl/sprite_pkg.sv
// Shared geometry defaults and FSM encoding for the bouncing-sprite motion scheduler.
package sprite_pkg;
    localparam int HC_DEF    = 800;
    localparam int VC_DEF    = 600;
    localparam int SW_DEF    = 200;
    localparam int SH_DEF    = 150;
    localparam int POS_W_DEF = 11;
    localparam int XMAX_DEF  = HC_DEF - SW_DEF;
    localparam int YMAX_DEF  = VC_DEF - SH_DEF;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STEP_H = 2'd1,
        STEP_V = 2'd2,
        COMMIT = 2'd3
    } state_t;
endpackage

// File: rtl/sprite_motion_ctrl_if.sv
// Host override channel: position/direction request with valid/ready handshake.
interface sprite_motion_ctrl_if #(
    parameter int POS_W = sprite_pkg::POS_W_DEF
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [POS_W-1:0] cmd_x;
    logic [POS_W-1:0] cmd_y;
    logic             cmd_dir_h;
    logic             cmd_dir_v;

    modport master (output cmd_valid, cmd_x, cmd_y, cmd_dir_h, cmd_dir_v, input cmd_ready);
    modport slave  (input cmd_valid, cmd_x, cmd_y, cmd_dir_h, cmd_dir_v, output cmd_ready);
endinterface

// File: rtl/sprite_axis_step.sv
// One-axis motion step: advances pos by step in dir, clamping and reversing at 0 / max.
module sprite_axis_step #(
    parameter int POS_W = sprite_pkg::POS_W_DEF
) (
    input  logic [POS_W-1:0] pos,
    input  logic             dir,
    input  logic [3:0]       step,
    input  logic [POS_W-1:0] max,
    output logic [POS_W-1:0] next_pos,
    output logic             next_dir,
    output logic             bounce
);
    logic [POS_W:0] pos_e;
    logic [POS_W:0] step_e;
    logic [POS_W:0] sum;

    assign pos_e  = {1'b0, pos};
    assign step_e = (POS_W+1)'(step);
    assign sum    = pos_e + step_e;

    always_comb begin
        next_pos = pos;
        next_dir = dir;
        bounce   = 1'b0;
        // A zero step never bounces, even when parked on an edge.
        if (step != 4'd0) begin
            if (dir) begin
                if (sum >= {1'b0, max}) begin
                    next_pos = max;
                    next_dir = 1'b0;
                    bounce   = 1'b1;
                end else begin
                    next_pos = sum[POS_W-1:0];
                end
            end else begin
                if (pos_e <= step_e) begin
                    next_pos = '0;
                    next_dir = 1'b1;
                    bounce   = 1'b1;
                end else begin
                    next_pos = pos - POS_W'(step);
                end
            end
        end
    end
endmodule

// File: rtl/sprite_motion_ctrl.sv
// Frame-synchronous sprite origin scheduler: steps during vblank, bounces at edges,
// accepts host overrides, and publishes the origin only after a COMMIT.
module sprite_motion_ctrl
    import sprite_pkg::*;
#(
    parameter int HC        = HC_DEF,
    parameter int VC        = VC_DEF,
    parameter int SW        = SW_DEF,
    parameter int SH        = SH_DEF,
    parameter int INIT_X    = 200,
    parameter int INIT_Y    = 200,
    parameter int FRAME_DIV = 1,
    parameter int POS_W     = POS_W_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               frame_tick,
    input  logic [3:0]         step,
    input  logic               pause,
    sprite_motion_ctrl_if.slave cmd,
    output logic [POS_W-1:0]   pos_x,
    output logic [POS_W-1:0]   pos_y,
    output logic               frame_done,
    output logic               bounce_h,
    output logic               bounce_v
);
    localparam logic [POS_W-1:0] XMAX     = POS_W'(HC - SW);
    localparam logic [POS_W-1:0] YMAX     = POS_W'(VC - SH);
    localparam int               DIV_W    = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);

    state_t           state;
    logic [POS_W-1:0] x, y;
    logic             dir_h, dir_v;
    logic [DIV_W-1:0] div_cnt;
    logic             commit_q;

    logic [POS_W-1:0] nx, ny, cx, cy;
    logic             ndh, ndv, bh, bv, hs;

    sprite_axis_step #(.POS_W(POS_W)) u_step_h (
        .pos(x), .dir(dir_h), .step(step), .max(XMAX),
        .next_pos(nx), .next_dir(ndh), .bounce(bh)
    );

    sprite_axis_step #(.POS_W(POS_W)) u_step_v (
        .pos(y), .dir(dir_v), .step(step), .max(YMAX),
        .next_pos(ny), .next_dir(ndv), .bounce(bv)
    );

    assign hs = cmd.cmd_valid && cmd.cmd_ready;
    assign cx = (cmd.cmd_x > XMAX) ? XMAX : cmd.cmd_x;
    assign cy = (cmd.cmd_y > YMAX) ? YMAX : cmd.cmd_y;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            x             <= POS_W'(INIT_X);
            y             <= POS_W'(INIT_Y);
            pos_x         <= POS_W'(INIT_X);
            pos_y         <= POS_W'(INIT_Y);
            dir_h         <= 1'b1;
            dir_v         <= 1'b1;
            div_cnt       <= '0;
            commit_q      <= 1'b0;
            cmd.cmd_ready <= 1'b1;
            frame_done    <= 1'b0;
            bounce_h      <= 1'b0;
            bounce_v      <= 1'b0;
        end else begin
            bounce_h   <= 1'b0;
            bounce_v   <= 1'b0;
            commit_q   <= 1'b0;
            frame_done <= commit_q;
            // Publish one cycle after COMMIT; x/y cannot move until IDLE has been reached.
            if (commit_q) begin
                pos_x <= x;
                pos_y <= y;
            end
            unique case (state)
                IDLE: begin
                    if (hs) begin
                        x     <= cx;
                        y     <= cy;
                        dir_h <= cmd.cmd_dir_h;
                        dir_v <= cmd.cmd_dir_v;
                    end
                    if (frame_tick) begin
                        cmd.cmd_ready <= 1'b0;
                        if (hs) begin
                            state <= COMMIT;
                        end else if (pause || div_cnt != DIV_LAST) begin
                            if (!pause) div_cnt <= div_cnt + DIV_W'(1);
                            state <= COMMIT;
                        end else begin
                            div_cnt <= '0;
                            state   <= STEP_H;
                        end
                    end
                end
                STEP_H: begin
                    x        <= nx;
                    dir_h    <= ndh;
                    bounce_h <= bh;
                    state    <= STEP_V;
                end
                STEP_V: begin
                    y        <= ny;
                    dir_v    <= ndv;
                    bounce_v <= bv;
                    state    <= COMMIT;
                end
                COMMIT: begin
                    commit_q      <= 1'b1;
                    cmd.cmd_ready <= 1'b1;
                    state         <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sprite_motion_ctrl.sv
// Bench for sprite_motion_ctrl: two instances (FRAME_DIV=1 and 3) checked against a position/direction model.
module tb_sprite_motion_ctrl;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick [2];
    logic        pause [2];
    logic [3:0]  step = 4'd1;
    logic [10:0] px [2];
    logic [10:0] py [2];
    logic        fd [2];
    logic        bh [2];
    logic        bv [2];

    int vectors = 0;
    int miscompares = 0;

    int mx [2], my [2], mdh [2], mdv [2], mdiv [2], mpx [2], mpy [2];
    int divs [2] = '{1, 3};

    sprite_motion_ctrl_if #(.POS_W(11)) ifa ();
    sprite_motion_ctrl_if #(.POS_W(11)) ifb ();

    always #5 clk = ~clk;

    sprite_motion_ctrl #(.FRAME_DIV(1)) dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(tick[0]), .step(step), .pause(pause[0]),
        .cmd(ifa.slave), .pos_x(px[0]), .pos_y(py[0]), .frame_done(fd[0]),
        .bounce_h(bh[0]), .bounce_v(bv[0])
    );

    sprite_motion_ctrl #(.FRAME_DIV(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .frame_tick(tick[1]), .step(step), .pause(pause[1]),
        .cmd(ifb.slave), .pos_x(px[1]), .pos_y(py[1]), .frame_done(fd[1]),
        .bounce_h(bh[1]), .bounce_v(bv[1])
    );

    function automatic logic rdy(input int k);
        return (k == 0) ? ifa.cmd_ready : ifb.cmd_ready;
    endfunction

    task automatic drive_cmd(input int k, input logic v, input int x, input int y, input int dh, input int dv);
        if (k == 0) begin
            ifa.cmd_valid = v; ifa.cmd_x = 11'(x); ifa.cmd_y = 11'(y);
            ifa.cmd_dir_h = dh[0]; ifa.cmd_dir_v = dv[0];
        end else begin
            ifb.cmd_valid = v; ifb.cmd_x = 11'(x); ifb.cmd_y = 11'(y);
            ifb.cmd_dir_h = dh[0]; ifb.cmd_dir_v = dv[0];
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 2; k++) begin
            mx[k] = 200; my[k] = 200; mdh[k] = 1; mdv[k] = 1;
            mdiv[k] = 0; mpx[k] = 200; mpy[k] = 200;
        end
    endfunction

    function automatic void model_load(input int k, input int x, input int y, input int dh, input int dv);
        mx[k] = (x > 600) ? 600 : x;
        my[k] = (y > 450) ? 450 : y;
        mdh[k] = dh; mdv[k] = dv;
    endfunction

    function automatic void mstep(inout int p, inout int d, input int s, input int lim, output bit b);
        int t;
        b = 1'b0;
        if (s == 0) return;
        t = d ? p + s : p - s;
        if (d != 0 && t >= lim) begin p = lim; d = 0; b = 1'b1; end
        else if (d == 0 && t <= 0) begin p = 0; d = 1; b = 1'b1; end
        else p = t;
    endfunction

    // Model of one accepted frame_tick; returns publish latency and expected bounces.
    function automatic void model_tick(input int k, input bit with_cmd, input bit pz,
                                       output int lat, output bit ebh, output bit ebv);
        ebh = 1'b0; ebv = 1'b0;
        if (with_cmd) lat = 2;
        else if (pz || mdiv[k] != divs[k] - 1) begin
            if (!pz) mdiv[k]++;
            lat = 2;
        end else begin
            mdiv[k] = 0;
            mstep(mx[k], mdh[k], int'(step), 600, ebh);
            mstep(my[k], mdv[k], int'(step), 450, ebv);
            lat = 4;
        end
        mpx[k] = mx[k]; mpy[k] = my[k];
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        tick[0] = 0; tick[1] = 0; pause[0] = 0; pause[1] = 0;
        drive_cmd(0, 0, 0, 0, 0, 0);
        drive_cmd(1, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic send_cmd(input int k, input int x, input int y, input int dh, input int dv);
        @(negedge clk);
        drive_cmd(k, 1, x, y, dh, dv);
        vectors++;
        if (rdy(k) !== 1'b1) begin
            miscompares++;
            $display("FAIL cmd_ready_idle[%0d]: got %b want 1", k, rdy(k));
        end
        @(posedge clk);
        @(negedge clk);
        drive_cmd(k, 0, 0, 0, 0, 0);
        model_load(k, x, y, dh, dv);
    endtask

    task automatic run_tick(input int k, input string name, input bit with_cmd,
                            input int cx, input int cy, input int cdh, input int cdv);
        int lat, nfd, fdc, ox, oy;
        bit ebh, ebv, sbh, sbv;
        ox = mpx[k]; oy = mpy[k];
        nfd = 0; fdc = -1; sbh = 0; sbv = 0;
        @(negedge clk);
        tick[k] = 1'b1;
        if (with_cmd) begin
            drive_cmd(k, 1, cx, cy, cdh, cdv);
            model_load(k, cx, cy, cdh, cdv);
        end
        model_tick(k, with_cmd, pause[k], lat, ebh, ebv);
        @(posedge clk);
        @(negedge clk);
        tick[k] = 1'b0;
        drive_cmd(k, 0, 0, 0, 0, 0);
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk);
            #1;
            if (fd[k]) begin nfd++; fdc = c; end
            sbh |= bh[k];
            sbv |= bv[k];
            if (c == lat - 1) begin
                vectors++;
                if (px[k] !== 11'(ox) || py[k] !== 11'(oy)) begin
                    miscompares++;
                    $display("FAIL %s early_pos: got %0d,%0d want %0d,%0d", name, px[k], py[k], ox, oy);
                end
            end
        end
        vectors++;
        if (nfd != 1 || fdc != lat) begin
            miscompares++;
            $display("FAIL %s frame_done: got %0d pulses at cycle %0d want 1 at %0d", name, nfd, fdc, lat);
        end
        vectors++;
        if (px[k] !== 11'(mpx[k]) || py[k] !== 11'(mpy[k])) begin
            miscompares++;
            $display("FAIL %s pos: got %0d,%0d want %0d,%0d", name, px[k], py[k], mpx[k], mpy[k]);
        end
        vectors++;
        if (sbh !== ebh || sbv !== ebv) begin
            miscompares++;
            $display("FAIL %s bounce: got h%b v%b want h%b v%b", name, sbh, sbv, ebh, ebv);
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        for (int k = 0; k < 2; k++) begin
            vectors++;
            if (px[k] !== 11'd200 || py[k] !== 11'd200 || fd[k] !== 1'b0 ||
                bh[k] !== 1'b0 || bv[k] !== 1'b0 || rdy(k) !== 1'b1) begin
                miscompares++;
                $display("FAIL reset[%0d]: got pos %0d,%0d fd%b bh%b bv%b rdy%b want 200,200 0 0 0 1",
                         k, px[k], py[k], fd[k], bh[k], bv[k], rdy(k));
            end
        end
    endtask

    task automatic test_basic_step();
        step = 4'd1;
        run_tick(0, "basic_step", 0, 0, 0, 0, 0);
    endtask

    task automatic test_far_bounce();
        step = 4'd1;
        send_cmd(0, 599, 449, 1, 1);
        run_tick(0, "far_bounce", 0, 0, 0, 0, 0);
        run_tick(0, "far_return", 0, 0, 0, 0, 0);
    endtask

    task automatic test_near_bounce();
        step = 4'd3;
        send_cmd(0, 2, 5, 0, 0);
        run_tick(0, "near_bounce_x", 0, 0, 0, 0, 0);
        run_tick(0, "near_bounce_y", 0, 0, 0, 0, 0);
        step = 4'd0;
        send_cmd(0, 900, 1000, 1, 1);
        run_tick(0, "clamp_step0", 0, 0, 0, 0, 0);
    endtask

    task automatic test_frame_div();
        step = 4'd2;
        for (int i = 1; i <= 8; i++) run_tick(1, $sformatf("div3_tick%0d", i), 0, 0, 0, 0, 0);
        pause[1] = 1'b1;
        run_tick(1, "div3_paused", 0, 0, 0, 0, 0);
        pause[1] = 1'b0;
        run_tick(1, "div3_resume", 0, 0, 0, 0, 0);
    endtask

    task automatic test_coincide();
        step = 4'd5;
        run_tick(0, "cmd_with_tick", 1, 100, 100, 1, 0);
    endtask

    task automatic test_tick_in_step_v();
        int nfd, lat;
        bit ebh, ebv;
        step = 4'd1;
        nfd = 0;
        @(negedge clk);
        tick[0] = 1'b1;
        model_tick(0, 0, 0, lat, ebh, ebv);
        @(posedge clk);
        @(negedge clk) tick[0] = 1'b0;
        @(posedge clk);
        @(negedge clk) tick[0] = 1'b1;
        @(posedge clk);
        @(negedge clk) tick[0] = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            if (fd[0]) nfd++;
        end
        vectors++;
        if (nfd != 1 || px[0] !== 11'(mpx[0]) || py[0] !== 11'(mpy[0])) begin
            miscompares++;
            $display("FAIL tick_in_step_v: got %0d pulses pos %0d,%0d want 1 pulse pos %0d,%0d",
                     nfd, px[0], py[0], mpx[0], mpy[0]);
        end
    endtask

    task automatic test_reset_mid();
        step = 4'd1;
        send_cmd(0, 300, 300, 0, 0);
        @(negedge clk);
        tick[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        tick[0] = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        vectors++;
        if (px[0] !== 11'd200 || py[0] !== 11'd200 || rdy(0) !== 1'b1 || fd[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid: got pos %0d,%0d rdy%b fd%b want 200,200 1 0", px[0], py[0], rdy(0), fd[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        run_tick(0, "after_reset_mid", 0, 0, 0, 0, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 24; i++) begin
            int k;
            k = i % 2;
            step = 4'($urandom_range(0, 15));
            pause[k] = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 2) == 0)
                send_cmd(k, $urandom_range(0, 1100), $urandom_range(0, 1100),
                         $urandom_range(0, 1), $urandom_range(0, 1));
            if ($urandom_range(0, 4) == 0)
                run_tick(k, $sformatf("rand%0d_cmd", i), 1, $urandom_range(0, 700),
                         $urandom_range(0, 500), $urandom_range(0, 1), $urandom_range(0, 1));
            else
                run_tick(k, $sformatf("rand%0d", i), 0, 0, 0, 0, 0);
        end
        pause[0] = 1'b0;
        pause[1] = 1'b0;
    endtask

    initial begin
        tick[0] = 0; tick[1] = 0; pause[0] = 0; pause[1] = 0;
        drive_cmd(0, 0, 0, 0, 0, 0);
        drive_cmd(1, 0, 0, 0, 0, 0);
        test_reset();
        test_basic_step();
        test_far_bounce();
        test_near_bounce();
        test_frame_div();
        test_coincide();
        test_tick_in_step_v();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
